// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
//
// Write-side address generator for the camera frame buffer. It takes 565 RGB
// pixels in landscape raster order (x fastest) and writes each one to the
// portrait-rotated address (IN_WIDTH-1-x)*IN_HEIGHT + y. The address is
// stepped incrementally, so no multiplier is needed. The block also checks
// frame length and reports short and overlong frames.
//
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-high reset
//   pixel_in         565 RGB pixel from the camera
//   pixel_valid_in   one-cycle strobe, pixel_in is valid
//   frame_done_in    one-cycle strobe, end of the camera frame
//   pixel_out        frame-buffer write data (dina)
//   pixel_valid_out  frame-buffer write enable (wea)
//   pixel_addr_out   frame-buffer write address (addra)
//   frame_ready_out  one-cycle pulse, a complete frame of the right size was written
//   overrun_out      one-cycle pulse, first excess pixel of a frame was dropped
//   short_out        one-cycle pulse, frame ended before it was full
//   frame_count_out  completed-frame counter (statistics build only)
//   error_count_out  saturating short+overrun counter (statistics build only)
//
// Optional feature macro: FRAME_WRITER_STATS_EN enables the two statistics
// counters. When the macro is undefined, both outputs are tied to zero.
// -----------------------------------------------------------------------------
module frame_writer #(
  parameter int unsigned IN_WIDTH  = 320,
  parameter int unsigned IN_HEIGHT = 240,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [15:0]       pixel_in,
  input  logic              pixel_valid_in,
  input  logic              frame_done_in,
  output logic [15:0]       pixel_out,
  output logic              pixel_valid_out,
  output logic [ADDR_W-1:0] pixel_addr_out,
  output logic              frame_ready_out,
  output logic              overrun_out,
  output logic              short_out,
  output logic [15:0]       frame_count_out,
  output logic [7:0]        error_count_out
);

  localparam int unsigned TOTAL = IN_WIDTH * IN_HEIGHT;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned XW    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  localparam logic [CNT_W-1:0]  TOTAL_C    = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [XW-1:0]     X_LAST     = XW'(IN_WIDTH - 1);
  localparam logic [XW-1:0]     X_ONE      = XW'(1);
  localparam logic [ADDR_W-1:0] LINE_BASE0 = ADDR_W'((IN_WIDTH - 1) * IN_HEIGHT);
  localparam logic [ADDR_W-1:0] HEIGHT_C   = ADDR_W'(IN_HEIGHT);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  state_t            state_q;
  logic [XW-1:0]     x_q,    x_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cnt_full_d;

  logic [15:0]       pixel_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic              ready_q;
  logic              overrun_q;
  logic              short_q;

  // Raster position after accepting one more pixel at the current position.
  always_comb begin
    x_d        = x_q;
    base_d     = base_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q + CNT_ONE;
    if (x_q == X_LAST) begin
      // End of a landscape line: next line starts one address above the old base.
      x_d    = '0;
      base_d = base_q + ADDR_ONE;
      addr_d = base_q + ADDR_ONE;
    end else begin
      x_d    = x_q + X_ONE;
      addr_d = addr_q - HEIGHT_C;
    end
    cnt_full_d = (cnt_d == TOTAL_C);
  end

  // Frame-state machine, position registers and registered write port / pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_SYNC;
      x_q        <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      pixel_q    <= '0;
      valid_q    <= 1'b0;
      addr_out_q <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      short_q   <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          // Wait for a frame boundary so that the first frame is aligned.
          if (frame_done_in) begin
            x_q     <= '0;
            cnt_q   <= '0;
            base_q  <= LINE_BASE0;
            addr_q  <= LINE_BASE0;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (pixel_valid_in) begin
            valid_q    <= 1'b1;
            pixel_q    <= pixel_in;
            addr_out_q <= addr_q;
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
          end
          if (frame_done_in) begin
            // A coincident pixel counts toward the frame that is ending.
            if (pixel_valid_in && cnt_full_d) begin
              ready_q <= 1'b1;
            end else begin
              short_q <= 1'b1;
            end
            x_q     <= '0;
            cnt_q   <= '0;
            base_q  <= LINE_BASE0;
            addr_q  <= LINE_BASE0;
            state_q <= ST_ACTIVE;
          end else if (pixel_valid_in && cnt_full_d) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pixel_valid_in) begin
            overrun_q <= 1'b1;
          end
          if (frame_done_in) begin
            // An excess pixel in the same cycle makes the frame overlong.
            if (!pixel_valid_in) begin
              ready_q <= 1'b1;
            end
            x_q     <= '0;
            cnt_q   <= '0;
            base_q  <= LINE_BASE0;
            addr_q  <= LINE_BASE0;
            state_q <= ST_ACTIVE;
          end else if (pixel_valid_in) begin
            state_q <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (frame_done_in) begin
            x_q     <= '0;
            cnt_q   <= '0;
            base_q  <= LINE_BASE0;
            addr_q  <= LINE_BASE0;
            state_q <= ST_ACTIVE;
          end
        end
        default: begin
          state_q <= ST_SYNC;
        end
      endcase
    end
  end

  assign pixel_out       = pixel_q;
  assign pixel_valid_out = valid_q;
  assign pixel_addr_out  = addr_out_q;
  assign frame_ready_out = ready_q;
  assign overrun_out     = overrun_q;
  assign short_out       = short_q;

`ifdef FRAME_WRITER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Statistics counters, advanced from the registered status pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      if (ready_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if ((short_q || overrun_q) && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign frame_count_out = frame_cnt_q;
  assign error_count_out = err_cnt_q;
`else
  assign frame_count_out = 16'd0;
  assign error_count_out = 8'd0;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer, using a reduced 8x4 frame so that
// several complete frames fit in a short run.
module tb_frame_writer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int AW    = 5;
  localparam int TOTAL = W * H;
  localparam logic [AW-1:0] BASE0 = 5'd28;   // (W-1)*H

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [15:0]   pixel_in;
  logic          pixel_valid_in;
  logic          frame_done_in;
  logic [15:0]   pixel_out;
  logic          pixel_valid_out;
  logic [AW-1:0] pixel_addr_out;
  logic          frame_ready_out;
  logic          overrun_out;
  logic          short_out;
  logic [15:0]   frame_count_out;
  logic [7:0]    error_count_out;

  int tests = 0;
  int fails = 0;

`ifdef FRAME_WRITER_STATS_EN
  localparam logic [15:0] FC_ONE = 16'd1;
  localparam logic [7:0]  EC_ONE = 8'd1;
`else
  localparam logic [15:0] FC_ONE = 16'd0;
  localparam logic [7:0]  EC_ONE = 8'd0;
`endif

  frame_writer #(.IN_WIDTH(W), .IN_HEIGHT(H), .ADDR_W(AW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .frame_done_in   (frame_done_in),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_addr_out  (pixel_addr_out),
    .frame_ready_out (frame_ready_out),
    .overrun_out     (overrun_out),
    .short_out       (short_out),
    .frame_count_out (frame_count_out),
    .error_count_out (error_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Portrait address of raster pixel i, straight from the rotation formula.
  function automatic logic [AW-1:0] exp_addr(input int i);
    int x;
    int y;
    x = i % W;
    y = i / W;
    return AW'((W - 1 - x) * H + y);
  endfunction

  function automatic logic [15:0] pix_of(input int i);
    return 16'(i * 37) ^ 16'h5A5A;
  endfunction

  // Drive one cycle of inputs, then sample #1 after the edge that consumed them.
  task automatic step(input logic v, input logic d, input logic [15:0] p);
    pixel_valid_in = v;
    frame_done_in  = d;
    pixel_in       = p;
    @(posedge clk_in);
    #1;
    pixel_valid_in = 1'b0;
    frame_done_in  = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    rst_in = 1'b0;
  endtask

  // Reset, open a frame, then feed n pixels without checking.
  task automatic start_frame(input int n);
    do_reset();
    step(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, pix_of(i));
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (pixel_out !== 16'h0 || pixel_valid_out !== 1'b0 || pixel_addr_out !== 5'd0 ||
        frame_ready_out !== 1'b0 || overrun_out !== 1'b0 || short_out !== 1'b0 ||
        frame_count_out !== 16'd0 || error_count_out !== 8'd0) begin
      fails++;
      $display("FAIL reset: data=%h v=%b addr=%0d rdy=%b ovr=%b sh=%b fc=%0d ec=%0d, want all 0",
               pixel_out, pixel_valid_out, pixel_addr_out, frame_ready_out, overrun_out,
               short_out, frame_count_out, error_count_out);
    end
  endtask

  task automatic test_sync_ignore();
    logic seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b0, pix_of(i));
      if (pixel_valid_out !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL sync_ignore: write seen=%b, want 0", seen);
    end
    step(1'b0, 1'b1, 16'h0000);
    tests++;
    if (short_out !== 1'b0 || frame_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL sync_done_pulse: short=%b ready=%b, want 0 0", short_out, frame_ready_out);
    end
    step(1'b1, 1'b0, 16'hBEEF);
    tests++;
    if (pixel_valid_out !== 1'b1 || pixel_addr_out !== BASE0 || pixel_out !== 16'hBEEF) begin
      fails++;
      $display("FAIL sync_first_px: v=%b addr=%0d data=%h, want 1 %0d beef",
               pixel_valid_out, pixel_addr_out, pixel_out, BASE0);
    end
  endtask

  task automatic test_full_frame();
    logic [AW-1:0] last_a;
    logic [15:0]   last_p;
    do_reset();
    step(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < TOTAL; i++) begin
      // Insert idle gaps inside the frame; they must not disturb addressing.
      if (i % 5 == 3) step(1'b0, 1'b0, 16'hFFFF);
      step(1'b1, 1'b0, pix_of(i));
      tests++;
      if (pixel_valid_out !== 1'b1 || pixel_addr_out !== exp_addr(i) ||
          pixel_out !== pix_of(i) || frame_ready_out !== 1'b0 || short_out !== 1'b0) begin
        fails++;
        $display("FAIL full_px%0d: v=%b addr=%0d data=%h rdy=%b sh=%b, want 1 %0d %h 0 0",
                 i, pixel_valid_out, pixel_addr_out, pixel_out, frame_ready_out, short_out,
                 exp_addr(i), pix_of(i));
      end
    end
    last_a = exp_addr(TOTAL - 1);
    last_p = pix_of(TOTAL - 1);
    step(1'b0, 1'b0, 16'h1234);
    tests++;
    if (pixel_valid_out !== 1'b0 || pixel_addr_out !== last_a || pixel_out !== last_p) begin
      fails++;
      $display("FAIL full_hold: v=%b addr=%0d data=%h, want 0 %0d %h",
               pixel_valid_out, pixel_addr_out, pixel_out, last_a, last_p);
    end
    step(1'b0, 1'b1, 16'h0000);
    tests++;
    if (frame_ready_out !== 1'b1 || short_out !== 1'b0 || overrun_out !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: rdy=%b sh=%b ovr=%b, want 1 0 0", frame_ready_out, short_out, overrun_out);
    end
    step(1'b0, 1'b0, 16'h0000);
    tests++;
    if (frame_ready_out !== 1'b0 || frame_count_out !== FC_ONE || error_count_out !== 8'd0) begin
      fails++;
      $display("FAIL full_after: rdy=%b fc=%0d ec=%0d, want 0 %0d 0",
               frame_ready_out, frame_count_out, error_count_out, FC_ONE);
    end
  endtask

  task automatic test_overrun();
    start_frame(TOTAL);
    step(1'b1, 1'b0, 16'hDEAD);
    tests++;
    if (pixel_valid_out !== 1'b0 || overrun_out !== 1'b1 || pixel_addr_out !== exp_addr(TOTAL - 1)) begin
      fails++;
      $display("FAIL overrun_first: v=%b ovr=%b addr=%0d, want 0 1 %0d",
               pixel_valid_out, overrun_out, pixel_addr_out, exp_addr(TOTAL - 1));
    end
    step(1'b1, 1'b0, 16'hDEAD);
    tests++;
    if (pixel_valid_out !== 1'b0 || overrun_out !== 1'b0) begin
      fails++;
      $display("FAIL overrun_second: v=%b ovr=%b, want 0 0", pixel_valid_out, overrun_out);
    end
    step(1'b0, 1'b1, 16'h0000);
    tests++;
    if (frame_ready_out !== 1'b0 || short_out !== 1'b0 || overrun_out !== 1'b0) begin
      fails++;
      $display("FAIL overrun_done: rdy=%b sh=%b ovr=%b, want 0 0 0", frame_ready_out, short_out, overrun_out);
    end
    step(1'b1, 1'b0, 16'h0F0F);
    tests++;
    if (pixel_valid_out !== 1'b1 || pixel_addr_out !== BASE0 ||
        error_count_out !== EC_ONE || frame_count_out !== 16'd0) begin
      fails++;
      $display("FAIL overrun_next: v=%b addr=%0d ec=%0d fc=%0d, want 1 %0d %0d 0",
               pixel_valid_out, pixel_addr_out, error_count_out, frame_count_out, BASE0, EC_ONE);
    end
  endtask

  task automatic test_full_valid_done();
    start_frame(TOTAL);
    step(1'b1, 1'b1, 16'h7777);
    tests++;
    if (pixel_valid_out !== 1'b0 || overrun_out !== 1'b1 || frame_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL full_vd: v=%b ovr=%b rdy=%b, want 0 1 0", pixel_valid_out, overrun_out, frame_ready_out);
    end
    step(1'b1, 1'b0, 16'h1111);
    tests++;
    if (pixel_valid_out !== 1'b1 || pixel_addr_out !== BASE0 || overrun_out !== 1'b0) begin
      fails++;
      $display("FAIL full_vd_next: v=%b addr=%0d ovr=%b, want 1 %0d 0",
               pixel_valid_out, pixel_addr_out, overrun_out, BASE0);
    end
  endtask

  task automatic test_short();
    start_frame(10);
    step(1'b0, 1'b1, 16'h0000);
    tests++;
    if (short_out !== 1'b1 || frame_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL short_pulse: sh=%b rdy=%b, want 1 0", short_out, frame_ready_out);
    end
    step(1'b1, 1'b0, 16'h2222);
    tests++;
    if (short_out !== 1'b0 || pixel_valid_out !== 1'b1 || pixel_addr_out !== BASE0) begin
      fails++;
      $display("FAIL short_next: sh=%b v=%b addr=%0d, want 0 1 %0d",
               short_out, pixel_valid_out, pixel_addr_out, BASE0);
    end
    step(1'b0, 1'b0, 16'h0000);
    tests++;
    if (error_count_out !== EC_ONE || frame_count_out !== 16'd0) begin
      fails++;
      $display("FAIL short_stats: ec=%0d fc=%0d, want %0d 0", error_count_out, frame_count_out, EC_ONE);
    end
  endtask

  task automatic test_coincident();
    start_frame(TOTAL - 1);
    step(1'b1, 1'b1, 16'hC0DE);
    tests++;
    if (pixel_valid_out !== 1'b1 || pixel_addr_out !== exp_addr(TOTAL - 1) || pixel_out !== 16'hC0DE ||
        frame_ready_out !== 1'b1 || short_out !== 1'b0) begin
      fails++;
      $display("FAIL coincident: v=%b addr=%0d data=%h rdy=%b sh=%b, want 1 %0d c0de 1 0",
               pixel_valid_out, pixel_addr_out, pixel_out, frame_ready_out, short_out, exp_addr(TOTAL - 1));
    end
    step(1'b1, 1'b0, 16'h3333);
    tests++;
    if (pixel_valid_out !== 1'b1 || pixel_addr_out !== BASE0 || frame_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL coincident_next: v=%b addr=%0d rdy=%b, want 1 %0d 0",
               pixel_valid_out, pixel_addr_out, frame_ready_out, BASE0);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    start_frame(10);
    rst_in = 1'b1;
    step(1'b1, 1'b0, 16'h4444);
    rst_in = 1'b0;
    tests++;
    if (pixel_out !== 16'h0 || pixel_valid_out !== 1'b0 || pixel_addr_out !== 5'd0 ||
        frame_ready_out !== 1'b0 || overrun_out !== 1'b0 || short_out !== 1'b0 ||
        frame_count_out !== 16'd0 || error_count_out !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: data=%h v=%b addr=%0d rdy=%b ovr=%b sh=%b fc=%0d ec=%0d, want all 0",
               pixel_out, pixel_valid_out, pixel_addr_out, frame_ready_out, overrun_out,
               short_out, frame_count_out, error_count_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, pix_of(i));
      if (pixel_valid_out !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_ignore: write seen=%b, want 0", seen);
    end
    step(1'b0, 1'b1, 16'h0000);
    tests++;
    if (short_out !== 1'b0 || frame_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_done: sh=%b rdy=%b, want 0 0", short_out, frame_ready_out);
    end
    step(1'b1, 1'b0, 16'h5555);
    tests++;
    if (pixel_valid_out !== 1'b1 || pixel_addr_out !== BASE0) begin
      fails++;
      $display("FAIL reset_mid_next: v=%b addr=%0d, want 1 %0d", pixel_valid_out, pixel_addr_out, BASE0);
    end
  endtask

  initial begin
    rst_in         = 1'b1;
    pixel_in       = 16'h0000;
    pixel_valid_in = 1'b0;
    frame_done_in  = 1'b0;
    test_reset();
    test_sync_ignore();
    test_full_frame();
    test_overrun();
    test_full_valid_done();
    test_short();
    test_coincident();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Write-side address generator and write-port driver for the camera frame buffer. It accepts 565 RGB pixels from the camera capture block in landscape raster order, rotates them pi/2 counter-clockwise into portrait order, and drives the 16-bit write port of the dual-port frame buffer. It also validates frame length and flags short and overlong frames. It sits between camera capture and the frame-buffer write side, replacing ad-hoc address counting in the top level.

## Interface
Parameters:
- IN_WIDTH, 320, camera pixels per line (landscape)
- IN_HEIGHT, 240, camera lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IN_WIDTH*IN_HEIGHT

Ports (one clock; reset is synchronous and active-high):
- clk_in  input  1  system clock (65 MHz domain)
- rst_in  input  1  synchronous active-high reset
- pixel_in  input  16  565 RGB pixel from camera
- pixel_valid_in  input  1  single-cycle strobe; pixel_in valid
- frame_done_in  input  1  single-cycle strobe; end of camera frame
- pixel_out  output  16  write data to frame buffer (dina)
- pixel_valid_out  output  1  write enable to frame buffer (wea)
- pixel_addr_out  output  ADDR_W  write address (addra)
- frame_ready_out  output  1  one-cycle pulse; a complete, correctly sized frame has been written
- overrun_out  output  1  one-cycle pulse; first excess pixel of a frame dropped
- short_out  output  1  one-cycle pulse; frame ended with fewer than IN_WIDTH*IN_HEIGHT pixels
- frame_count_out  output  16  completed-frame counter (see Configuration)
- error_count_out  output  8  short+overrun frame counter (see Configuration)

## Operation
- Input pixel index: x in 0..IN_WIDTH-1 (column), y in 0..IN_HEIGHT-1 (line), raster order, x fastest.
- Output address: (IN_WIDTH-1-x)*IN_HEIGHT + y. Computed incrementally, no multiplier:
  - first pixel of frame: line_base = (IN_WIDTH-1)*IN_HEIGHT (76560), addr = line_base
  - each accepted pixel with x < IN_WIDTH-1: addr -= IN_HEIGHT
  - x wraps at IN_WIDTH-1: y += 1, line_base += 1, next addr = line_base
- States:
  - SYNC (reset state): pixels ignored; frame_done_in -> ACTIVE with counters cleared.
  - ACTIVE: each pixel_valid_in produces one write. Pixel count reaching IN_WIDTH*IN_HEIGHT -> FULL. frame_done_in with count < total -> pulse short_out, clear counters, stay ACTIVE.
  - FULL: frame_done_in -> pulse frame_ready_out, clear counters, ACTIVE. pixel_valid_in -> no write, pulse overrun_out, -> DROP.
  - DROP: pixels ignored, no further pulses; frame_done_in -> clear counters, ACTIVE.
- Simultaneous pixel_valid_in and frame_done_in: pixel handled first as part of the ending frame (written, or dropped, per current state), then the frame_done transition applies to the updated count. In SYNC the pixel is discarded.
- Gaps in pixel_valid_in of any length have no effect.

## Timing
- Latency 1 cycle: pixel_valid_in at cycle N -> pixel_valid_out, pixel_out, pixel_addr_out registered at N+1.
- frame_ready_out, short_out, overrun_out: registered, asserted at N+1 for the triggering event at N, exactly one cycle.
- pixel_out and pixel_addr_out hold their last values when pixel_valid_out is low.
- Reset: all outputs 0, state SYNC, line_base/addr/counters cleared. Reset mid-frame discards the frame; no pulse is emitted.

## Configuration
- FRAME_WRITER_STATS_EN defined: frame_count_out increments (wrapping at 16 bits) on each frame_ready_out pulse. error_count_out increments on each short_out or overrun_out pulse and saturates at 255. Both clear on rst_in.
- Not defined: frame_count_out and error_count_out are tied to 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- Reset, frame_done, 76800 pixels -> addrs 76560, 76320, ... pixel 319 at 0, pixel 320 at 76561, last at 239; frame_done -> frame_ready_out one cycle; frame_count_out = 1.
- After reset, 500 pixels before the first frame_done -> pixel_valid_out never asserted. frame_done, then a pixel -> written at 76560.
- 76801 pixels then frame_done -> 76800 writes; pixel 76801 not written; overrun_out one pulse; no frame_ready_out; error_count_out = 1 (stats on). Next frame starts at 76560.
- 1000 pixels then frame_done -> short_out pulse, no frame_ready_out. Next frame's first pixel at 76560.
- pixel 76800 coincident with frame_done -> written at addr 239 at N+1; frame_ready_out at N+1.
- rst_in asserted mid-frame (pixel 4000) -> all outputs 0 next cycle, no pulses, SYNC. Pixels ignored until frame_done.
